if_fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the instruction cache. It owns the PC and drives the cache's CPU_REQ/CPU_REQ_ADDR request port. It buffers returned instructions, with their PCs, in a small FIFO for decode, and handles branch/jump redirects, including redirects that arrive while a cache miss refill is in flight.

---
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 tb/tb_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Function : Instruction-fetch front end. Owns the PC, drives the I-cache
//            request port, buffers {PC, instruction} pairs for decode and
//            handles redirects, including ones that land during a miss.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_fetch_unit #(
    parameter int                    DEPTH    = 4,
    parameter logic [`PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    output logic                     CPU_REQ,
    output logic [`PC_WIDTH-1:0]     CPU_REQ_ADDR,
    input  logic                     CPU_REQ_VALID,
    input  logic [`DATA_WIDTH-1:0]   CPU_REQ_DATA,
    output logic                     IF_VALID,
    input  logic                     IF_READY,
    output logic [`DATA_WIDTH-1:0]   IF_INSTR,
    output logic [`PC_WIDTH-1:0]     IF_PC,
    input  logic                     REDIRECT,
    input  logic [`PC_WIDTH-1:0]     REDIRECT_PC
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  C_ONE   = (PTR_W+1)'(1);

    logic [`PC_WIDTH-1:0]   pc_q;
    logic [`PC_WIDTH-1:0]   rpc_q;
    logic                   pend_q;
    logic                   rpend_q;
    logic                   start_q;
    logic [PTR_W:0]         count_q;
    logic [PTR_W-1:0]       wptr_q;
    logic [PTR_W-1:0]       rptr_q;
    logic [`PC_WIDTH-1:0]   mem_pc_q    [DEPTH];
    logic [`DATA_WIDTH-1:0] mem_instr_q [DEPTH];

    logic                   w_req;
    logic                   w_inflight;
    logic                   w_accept;
    logic                   w_pop;
    logic [`PC_WIDTH-1:0]   w_redir_pc;

    assign w_req      = start_q && (pend_q || rpend_q || (count_q < C_DEPTH));
    // A request issued this cycle without a response is already in flight at
    // the cache, so its address must be held even before pend_q is set.
    assign w_inflight = w_req && !CPU_REQ_VALID;
    assign w_accept   = CPU_REQ_VALID && !rpend_q && !REDIRECT;
    assign w_pop      = IF_VALID && IF_READY && !REDIRECT;
    assign w_redir_pc = REDIRECT_PC & ~`PC_WIDTH'(3);

    assign CPU_REQ      = w_req;
    assign CPU_REQ_ADDR = pc_q;
    assign IF_VALID     = (count_q != '0);
    assign IF_PC        = mem_pc_q[rptr_q];
    assign IF_INSTR     = mem_instr_q[rptr_q];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pc_q    <= RESET_PC;
            rpc_q   <= '0;
            pend_q  <= 1'b0;
            rpend_q <= 1'b0;
            start_q <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            start_q <= 1'b1;
            pend_q  <= w_inflight;

            if (REDIRECT && w_inflight) begin
                rpend_q <= 1'b1;
                rpc_q   <= w_redir_pc;
            end else if (REDIRECT) begin
                pc_q    <= w_redir_pc;
                rpend_q <= 1'b0;
            end else if (CPU_REQ_VALID && rpend_q) begin
                pc_q    <= rpc_q;
                rpend_q <= 1'b0;
            end else if (w_accept) begin
                pc_q    <= pc_q + `PC_WIDTH'(4);
            end

            if (REDIRECT) begin
                count_q <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else begin
                if (w_accept) begin
                    mem_pc_q[wptr_q]    <= pc_q;
                    mem_instr_q[wptr_q] <= CPU_REQ_DATA;
                    wptr_q              <= wptr_q + 1'b1;
                end
                if (w_pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                if (w_accept && !w_pop) begin
                    count_q <= count_q + C_ONE;
                end else if (!w_accept && w_pop) begin
                    count_q <= count_q - C_ONE;
                end
            end
        end
    end

    a_no_overflow : assert property (@(posedge ACLK) disable iff (!ARESETn)
        !(w_accept && (count_q == C_DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Function : Self-checking bench for if_fetch_unit: directed vector table,
//            hand-written miss/redirect/reset sequences, randomized traffic
//            against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_if_fetch_unit;

    localparam int DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        CPU_REQ;
    logic [31:0] CPU_REQ_ADDR;
    logic        CPU_REQ_VALID = 1'b0;
    logic [31:0] CPU_REQ_DATA = '0;
    logic        IF_VALID;
    logic        IF_READY = 1'b0;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;

    int vectors = 0;
    int miscompares = 0;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .CPU_REQ       (CPU_REQ),
        .CPU_REQ_ADDR  (CPU_REQ_ADDR),
        .CPU_REQ_VALID (CPU_REQ_VALID),
        .CPU_REQ_DATA  (CPU_REQ_DATA),
        .IF_VALID      (IF_VALID),
        .IF_READY      (IF_READY),
        .IF_INSTR      (IF_INSTR),
        .IF_PC         (IF_PC),
        .REDIRECT      (REDIRECT),
        .REDIRECT_PC   (REDIRECT_PC)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        v;
        logic        r;
        logic        rd;
        logic [31:0] rdpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eifv;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t tbl [15];

    function automatic logic [31:0] f_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic rd,
                         input logic [31:0] rdpc, input logic [31:0] data);
        @(negedge ACLK);
        CPU_REQ_VALID = v;
        IF_READY      = r;
        REDIRECT      = rd;
        REDIRECT_PC   = rdpc;
        CPU_REQ_DATA  = data;
        #1;
    endtask

    task automatic do_reset();
        ARESETn       = 1'b0;
        CPU_REQ_VALID = 1'b0;
        IF_READY      = 1'b0;
        REDIRECT      = 1'b0;
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
    endtask

    // reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    logic        m_disc;
    logic        m_busy;
    logic        m_started;
    logic        m_req;

    initial begin
        // Directed table from reset: fill, stall when full, drain, redirect on
        // a hit, redirect during a miss, then fetch from the target.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 32'h14,  1'b1, 32'h8};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h200, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].rd, tbl[i].rdpc, f_data(tbl[i].eaddr));
            chk($sformatf("tbl%0d_req", i),  CPU_REQ,      tbl[i].ereq);
            chk($sformatf("tbl%0d_addr", i), CPU_REQ_ADDR, tbl[i].eaddr);
            chk($sformatf("tbl%0d_ifv", i),  IF_VALID,     tbl[i].eifv);
            if (tbl[i].eifv) begin
                chk($sformatf("tbl%0d_ifpc", i),  IF_PC,    tbl[i].epc);
                chk($sformatf("tbl%0d_instr", i), IF_INSTR, f_data(tbl[i].epc));
            end
        end

        // Long miss with three entries buffered: address must hold for 18 cycles.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h14, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, f_data(32'h14));
        drive(1'b1, 1'b0, 1'b0, 32'h0, f_data(32'h18));
        drive(1'b1, 1'b0, 1'b0, 32'h0, f_data(32'h1C));
        for (int k = 0; k < 18; k++) begin
            drive(k == 17, 1'b0, 1'b0, 32'h0, f_data(32'h20));
            chk($sformatf("miss_req_c%0d", k),  CPU_REQ,      1'b1);
            chk($sformatf("miss_addr_c%0d", k), CPU_REQ_ADDR, 32'h20);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("full_req",   CPU_REQ,      1'b0);
        chk("full_addr",  CPU_REQ_ADDR, 32'h24);
        chk("full_ifpc",  IF_PC,        32'h14);
        chk("full_instr", IF_INSTR,     f_data(32'h14));

        // Miss at 0x24, redirect while in flight, then reset mid-discard.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rp_req0", CPU_REQ, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
        chk("rp_req1", CPU_REQ, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rp_hold_addr", CPU_REQ_ADDR, 32'h24);
        chk("rp_flushed",   IF_VALID,     1'b0);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk("arst_req",   CPU_REQ,      1'b0);
        chk("arst_addr",  CPU_REQ_ADDR, 32'h0);
        chk("arst_ifv",   IF_VALID,     1'b0);
        chk("arst_ifpc",  IF_PC,        32'h0);
        chk("arst_instr", IF_INSTR,     32'h0);
        @(posedge ACLK);
        #2 ARESETn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rel_req", CPU_REQ, 1'b0);
        chk("rel_ifv", IF_VALID, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, f_data(32'h0));
        chk("rel_req1",  CPU_REQ,      1'b1);
        chk("rel_addr1", CPU_REQ_ADDR, 32'h0);
        chk("rel_ifv1",  IF_VALID,     1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rel_ifv2",   IF_VALID, 1'b1);
        chk("rel_ifpc2",  IF_PC,    32'h0);
        chk("rel_instr2", IF_INSTR, f_data(32'h0));

        // Randomized traffic against the queue model.
        do_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_dpc     = 32'h0;
        m_disc    = 1'b0;
        m_busy    = 1'b0;
        m_started = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic        v, r, rd;
            logic [31:0] rdpc;
            ent_t        e;
            m_req = m_started && (m_busy || (m_q.size() < DEPTH));
            v  = m_req && ($urandom_range(0, 2) != 0);
            r  = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 11) == 0;
            rdpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : ($urandom & 32'h0000_0FFF);
            @(negedge ACLK);
            CPU_REQ_VALID = v;
            IF_READY      = r;
            REDIRECT      = rd;
            REDIRECT_PC   = rdpc;
            CPU_REQ_DATA  = f_data(m_pc);
            #1;
            chk("rnd_req",  CPU_REQ,      m_req);
            chk("rnd_addr", CPU_REQ_ADDR, m_pc);
            chk("rnd_ifv",  IF_VALID,     m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rnd_ifpc",  IF_PC,    m_q[0].pc);
                chk("rnd_instr", IF_INSTR, m_q[0].instr);
            end
            if (rd) begin
                if (m_req && !v) begin
                    m_disc = 1'b1;
                    m_dpc  = rdpc & ~32'h3;
                end else begin
                    m_pc   = rdpc & ~32'h3;
                    m_disc = 1'b0;
                end
                m_q.delete();
            end else begin
                if (r && m_q.size() != 0) void'(m_q.pop_front());
                if (v) begin
                    if (m_disc) begin
                        m_pc   = m_dpc;
                        m_disc = 1'b0;
                    end else begin
                        e.pc    = m_pc;
                        e.instr = f_data(m_pc);
                        m_q.push_back(e);
                        m_pc = m_pc + 32'h4;
                    end
                end
            end
            m_busy    = m_req && !v;
            m_started = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
